ro_scheduler: RTL

RO_SCHEDULER -- requirements
Module: ro_scheduler

---
 rtl/ro_sched_pkg.sv | 22 ++
 rtl/ro_slot_timer.sv | 47 ++++
 rtl/ro_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ro_sched_pkg.sv
// Shared definitions for the readout-line scheduler: FSM state encoding,
// default sizing constants and the binary-to-Gray helper.
package ro_sched_pkg;

  localparam int unsigned DEF_NUM_CH   = 8;
  localparam int unsigned DEF_SLOT_LEN = 4;
  // Widest channel index supported (NUM_CH up to 16).
  localparam int unsigned MAX_IDX_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_SLOT  = 2'd2,
    ST_GUARD = 2'd3
  } state_e;

  // Reflected binary Gray code of a channel index.
  function automatic logic [MAX_IDX_W-1:0] bin2gray(input logic [MAX_IDX_W-1:0] bin);
    return bin ^ (bin >> 1'd1);
  endfunction

endpackage

// File: rtl/ro_slot_timer.sv
// Slot-length down-counter. load_i arms it for a fresh slot; while count_i is
// high it counts down to zero. last_o marks the cycle before the final slot
// cycle, done_o marks the final slot cycle itself.
module ro_slot_timer
  import ro_sched_pkg::*;
#(
  parameter int unsigned SLOT_LEN = DEF_SLOT_LEN
) (
  input  logic clk_master,
  input  logic rstb,
  input  logic load_i,
  input  logic count_i,
  output logic done_o,
  output logic last_o
);

  localparam int unsigned   CW       = $clog2(SLOT_LEN);
  localparam logic [CW-1:0] LOAD_VAL = CW'(SLOT_LEN - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: reload on slot entry, otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (count_i && (cnt_q != CW'(0))) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= CW'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = count_i & (cnt_q == CW'(0));
  assign last_o = count_i & (cnt_q == CW'(1));

endmodule

// File: rtl/ro_scheduler.sv
// Time-division scheduler for a tri-state readout line shared by NUM_CH
// channels. A frame is one SYNC cycle followed, per channel, by a SLOT of
// SLOT_LEN cycles and a one-cycle GUARD gap so that two drivers are never on
// the line in the same or adjacent cycles. All outputs come from flops that
// are loaded with the decode of the next state, and all of them are cleared
// asynchronously by rstb.
// Build option: define RO_SKIP_IDLE_EN to skip channels whose ch_valid bit is
// low when the next slot is chosen; otherwise every channel gets a slot.
module ro_scheduler
  import ro_sched_pkg::*;
#(
  parameter int unsigned NUM_CH   = DEF_NUM_CH,
  parameter int unsigned SLOT_LEN = DEF_SLOT_LEN
) (
  input  logic                       clk_master,
  input  logic                       rstb,
  input  logic                       enable,
  input  logic [NUM_CH-1:0]          ch_valid,
  output logic [NUM_CH-1:0]          grant,
  output logic [NUM_CH-1:0]          ch_ack,
  output logic                       frame_sync,
  output logic [$clog2(NUM_CH)-1:0]  slot_gray,
  output logic                       busy
);

  localparam int unsigned       IW    = $clog2(NUM_CH);
  localparam logic [NUM_CH-1:0] ONE   = NUM_CH'(1);
  localparam logic [NUM_CH-1:0] ZEROS = {NUM_CH{1'b0}};

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic              sync_q, sync_d;
  logic [IW-1:0]     gray_q, gray_d;
  logic              busy_q, busy_d;

  logic [NUM_CH-1:0] valid_s;
  logic [IW:0]       start_s;
  logic              nxt_found_s;
  logic [IW-1:0]     nxt_idx_s;
  logic              load_s;
  logic              tmr_count_s;
  logic              tmr_done_s;
  logic              tmr_last_s;

`ifdef RO_SKIP_IDLE_EN
  assign valid_s = ch_valid;
`else
  // Every channel is eligible; ch_valid has no effect in this build.
  assign valid_s = ch_valid | {NUM_CH{1'b1}};
`endif

  // Leaving SYNC the search starts at channel 0; leaving GUARD it starts just
  // above the channel that was served.
  assign start_s     = (state_q == ST_SYNC) ? {(IW+1){1'b0}} : ({1'b0, idx_q} + (IW+1)'(1));
  assign tmr_count_s = (state_q == ST_SLOT);

  // Lowest eligible channel at or above start_s.
  always_comb begin
    nxt_found_s = 1'b0;
    nxt_idx_s   = {IW{1'b0}};
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (valid_s[k] && ((IW+1)'(k) >= start_s)) begin
        nxt_found_s = 1'b1;
        nxt_idx_s   = IW'(k);
      end else begin
        nxt_found_s = nxt_found_s;
        nxt_idx_s   = nxt_idx_s;
      end
    end
  end

  ro_slot_timer #(
    .SLOT_LEN (SLOT_LEN)
  ) u_slot_timer (
    .clk_master (clk_master),
    .rstb       (rstb),
    .load_i     (load_s),
    .count_i    (tmr_count_s),
    .done_o     (tmr_done_s),
    .last_o     (tmr_last_s)
  );

  // Next-state and channel-index logic; the frame always runs to its end
  // regardless of enable, which is only consulted in IDLE and at frame end.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = {IW{1'b0}};
        if (enable) begin
          state_d = ST_SYNC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC, ST_GUARD: begin
        if (nxt_found_s) begin
          state_d = ST_SLOT;
          idx_d   = nxt_idx_s;
          load_s  = 1'b1;
        end else if (enable) begin
          state_d = ST_SYNC;
          idx_d   = {IW{1'b0}};
        end else begin
          state_d = ST_IDLE;
          idx_d   = {IW{1'b0}};
        end
      end
      ST_SLOT: begin
        if (tmr_done_s) begin
          state_d = ST_GUARD;
        end else begin
          state_d = ST_SLOT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IW{1'b0}};
      end
    endcase
  end

  // Output decode of the next state, so every output is a plain flop.
  always_comb begin
    grant_d = ZEROS;
    ack_d   = ZEROS;
    sync_d  = (state_d == ST_SYNC);
    busy_d  = (state_d != ST_IDLE);
    gray_d  = {IW{1'b0}};
    if (state_d == ST_SLOT) begin
      grant_d = ONE << idx_d;
    end else begin
      grant_d = ZEROS;
    end
    if ((state_d == ST_SLOT) || (state_d == ST_GUARD)) begin
      gray_d = IW'(bin2gray(MAX_IDX_W'(idx_d)));
    end else begin
      gray_d = {IW{1'b0}};
    end
    // The slot stays on the same channel when the timer says the next
    // cycle is the last one, so ack that channel then.
    if (tmr_last_s) begin
      ack_d = ONE << idx_q;
    end else begin
      ack_d = ZEROS;
    end
  end

  // State, index and output registers; reset releases the line immediately.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      idx_q   <= {IW{1'b0}};
      grant_q <= ZEROS;
      ack_q   <= ZEROS;
      sync_q  <= 1'b0;
      gray_q  <= {IW{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      sync_q  <= sync_d;
      gray_q  <= gray_d;
      busy_q  <= busy_d;
    end
  end

  assign grant      = grant_q;
  assign ch_ack     = ack_q;
  assign frame_sync = sync_q;
  assign slot_gray  = gray_q;
  assign busy       = busy_q;

endmodule
